// File: rtl/mapping_table_if.sv
// rtl/mapping_table_if.sv - storage-result and map-lookup bundle for mapping_table
// Purpose : carries logical weight rows out to faulty-PE storage, its
//           match results back, and the logical->physical row lookup.
// Signals : weight_valid, current_row_addr  - row presented to storage
//           match_success, match_failed     - result for the previous-cycle row
//           faulty_row_addr                 - physical row assigned on success
//           map_rd_addr / map_rd_phys       - combinational map lookup
// Modports: master = storage/lookup client side, slave = mapping_table side.
interface mapping_table_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  weight_valid;
  logic [ADDR_WIDTH-1:0] current_row_addr;
  logic                  match_success;
  logic                  match_failed;
  logic [ADDR_WIDTH-1:0] faulty_row_addr;
  logic [ADDR_WIDTH-1:0] map_rd_addr;
  logic [ADDR_WIDTH-1:0] map_rd_phys;

  modport master (
    output weight_valid, current_row_addr, match_success, match_failed,
           faulty_row_addr, map_rd_addr,
    input  map_rd_phys
  );

  modport slave (
    input  weight_valid, current_row_addr, match_success, match_failed,
           faulty_row_addr, map_rd_addr,
    output map_rd_phys
  );
endinterface

// File: rtl/mapping_table.sv
// rtl/mapping_table.sv - logical-to-physical systolic row mapping around faulty rows
// Purpose : collects per-row match results from faulty-PE storage, then
//           allocates every unmatched logical row to a free physical row,
//           preferring fault-free rows.
// Ports   : clk, rst_n (async, active-low), start, faulty_rows_mask,
//           bus (mapping_table_if.slave), row_used, busy, mapping_done,
//           mapping_fail, protocol_err.
module mapping_table #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
  mapping_table_if.slave           bus,
  output logic [SYSTOLIC_SIZE-1:0] row_used,
  output logic                     busy,
  output logic                     mapping_done,
  output logic                     mapping_fail,
  output logic                     protocol_err
);
  localparam int N  = SYSTOLIC_SIZE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ALLOC, S_DONE, S_FAIL} state_t;

  state_t                state_q;
  logic [N-1:0]          mask_q;
  logic [N-1:0]          defer_q;
  logic [N-1:0]          seen_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] pend_q;
  logic                  fail_flag_q;
  logic [ADDR_WIDTH-1:0] map_q [N];

  logic                  defer_any;
  logic [ADDR_WIDTH-1:0] defer_idx;
  logic                  clean_any;
  logic [ADDR_WIDTH-1:0] clean_idx;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic [ADDR_WIDTH-1:0] alloc_phys;
  logic [N-1:0]          defer_clr;
  logic                  alloc_fail;
  logic                  alloc_last;
  logic                  res_any;
  logic                  res_both;
  logic [CW-1:0]         cnt_inc;

  assign bus.map_rd_phys = map_q[bus.map_rd_addr];

  assign res_any  = bus.match_success | bus.match_failed;
  assign res_both = bus.match_success & bus.match_failed;
  assign cnt_inc  = cnt_q + CW'(1);

  // Lowest-index priority encoders: scanning downward lets the last hit win.
  always_comb begin
    defer_any = 1'b0;
    defer_idx = '0;
    clean_any = 1'b0;
    clean_idx = '0;
    free_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (defer_q[i]) begin
        defer_any = 1'b1;
        defer_idx = ADDR_WIDTH'(i);
      end
      if (!row_used[i]) begin
        free_idx = ADDR_WIDTH'(i);
        if (!mask_q[i]) begin
          clean_any = 1'b1;
          clean_idx = ADDR_WIDTH'(i);
        end
      end
    end
    // Fall back to a faulty row only when every fault-free row is taken.
    alloc_phys = clean_any ? clean_idx : free_idx;
    defer_clr  = defer_q;
    if (defer_any) defer_clr[defer_idx] = 1'b0;
    alloc_fail = fail_flag_q | (defer_any & mask_q[alloc_phys]);
    alloc_last = (defer_clr == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      defer_q      <= '0;
      seen_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      fail_flag_q  <= 1'b0;
      row_used     <= '0;
      busy         <= 1'b0;
      mapping_done <= 1'b0;
      mapping_fail <= 1'b0;
      protocol_err <= 1'b0;
      for (int i = 0; i < N; i++) map_q[i] <= ADDR_WIDTH'(i);
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_q      <= S_COLLECT;
            mask_q       <= faulty_rows_mask;
            defer_q      <= '0;
            seen_q       <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            fail_flag_q  <= 1'b0;
            row_used     <= '0;
            busy         <= 1'b1;
            mapping_done <= 1'b0;
            mapping_fail <= 1'b0;
            protocol_err <= 1'b0;
            for (int i = 0; i < N; i++) map_q[i] <= ADDR_WIDTH'(i);
          end else if (res_any) begin
            protocol_err <= 1'b1;
          end
        end

        S_COLLECT: begin
          // pend_q still holds last cycle's row while the result for it lands.
          if (bus.weight_valid) pend_q <= bus.current_row_addr;
          if (res_any) begin
            if (res_both || seen_q[pend_q]) begin
              protocol_err <= 1'b1;
            end else begin
              if (bus.match_success) begin
                map_q[pend_q]                <= bus.faulty_row_addr;
                row_used[bus.faulty_row_addr] <= 1'b1;
              end else begin
                defer_q[pend_q] <= 1'b1;
              end
              seen_q[pend_q] <= 1'b1;
              cnt_q          <= cnt_inc;
              if (cnt_inc == CW'(N)) state_q <= S_ALLOC;
            end
          end
        end

        S_ALLOC: begin
          if (res_any) protocol_err <= 1'b1;
          if (defer_any) begin
            map_q[defer_idx]     <= alloc_phys;
            row_used[alloc_phys] <= 1'b1;
            defer_q              <= defer_clr;
            fail_flag_q          <= alloc_fail;
          end
          if (alloc_last) begin
            state_q      <= alloc_fail ? S_FAIL : S_DONE;
            busy         <= 1'b0;
            mapping_done <= 1'b1;
            mapping_fail <= alloc_fail;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mapping_table.sv
// tb/tb_mapping_table.sv - randomized and directed self-checking bench for mapping_table
module tb_mapping_table;
  localparam int N  = 8;
  localparam int AW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] faulty_rows_mask = '0;
  logic [N-1:0] row_used;
  logic         busy;
  logic         mapping_done;
  logic         mapping_fail;
  logic         protocol_err;

  mapping_table_if #(.ADDR_WIDTH(AW)) bus ();

  mapping_table #(.SYSTOLIC_SIZE(N), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .faulty_rows_mask (faulty_rows_mask),
    .bus              (bus.slave),
    .row_used         (row_used),
    .busy             (busy),
    .mapping_done     (mapping_done),
    .mapping_fail     (mapping_fail),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Operation list for one session: logical row, 1 = match_success, phys row.
  int op_row[$];
  int op_ok[$];
  int op_phys[$];

  int           exp_map[N];
  logic [N-1:0] exp_used;
  bit           exp_fail;
  bit           exp_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: replay results in arrival order, then give each deferred row
  // (ascending) the lowest free clean row, else the lowest free row.
  function automatic void model(input logic [N-1:0] m);
    bit seen[N];
    bit deferred[N];
    int cnt = 0;
    exp_used = '0;
    exp_fail = 0;
    exp_perr = 0;
    for (int i = 0; i < N; i++) begin
      exp_map[i] = i; seen[i] = 0; deferred[i] = 0;
    end
    for (int k = 0; k < op_row.size(); k++) begin
      if (cnt == N || seen[op_row[k]]) begin
        exp_perr = 1;
      end else begin
        seen[op_row[k]] = 1;
        cnt++;
        if (op_ok[k] != 0) begin
          exp_map[op_row[k]] = op_phys[k];
          exp_used[op_phys[k]] = 1'b1;
        end else begin
          deferred[op_row[k]] = 1;
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      if (deferred[r]) begin
        int p = -1;
        for (int q = 0; q < N; q++)
          if (p < 0 && !exp_used[q] && !m[q]) p = q;
        for (int q = 0; q < N; q++)
          if (p < 0 && !exp_used[q]) p = q;
        exp_map[r] = p;
        exp_used[p] = 1'b1;
        if (m[p]) exp_fail = 1;
      end
    end
  endfunction

  task automatic idle_bus();
    bus.weight_valid     = 1'b0;
    bus.current_row_addr = '0;
    bus.match_success    = 1'b0;
    bus.match_failed     = 1'b0;
    bus.faulty_row_addr  = '0;
  endtask

  task automatic drive_result(input int k);
    if (k < 0) begin
      bus.match_success   = 1'b0;
      bus.match_failed    = 1'b0;
      bus.faulty_row_addr = '0;
    end else begin
      bus.match_success   = (op_ok[k] != 0);
      bus.match_failed    = (op_ok[k] == 0);
      bus.faulty_row_addr = (op_ok[k] != 0) ? AW'(op_phys[k]) : AW'($urandom_range(0, N - 1));
    end
  endtask

  task automatic clear_ops();
    op_row.delete(); op_ok.delete(); op_phys.delete();
  endtask

  task automatic push_op(input int r, input int ok, input int p);
    op_row.push_back(r); op_ok.push_back(ok); op_phys.push_back(p);
  endtask

  task automatic all_failed();
    clear_ops();
    for (int i = 0; i < N; i++) push_op(i, 0, 0);
  endtask

  task automatic start_and_drive(input logic [N-1:0] m, input bit gaps);
    int prev = -1;
    model(m);
    @(negedge clk);
    start = 1'b1;
    faulty_rows_mask = m;
    @(negedge clk);
    start = 1'b0;
    faulty_rows_mask = N'($urandom);
    check("busy_after_start", busy, 1);
    check("perr_after_start", protocol_err, 0);
    check("used_after_start", row_used, 0);
    for (int k = 0; k < op_row.size(); k++) begin
      bus.weight_valid     = 1'b1;
      bus.current_row_addr = AW'(op_row[k]);
      drive_result(prev);
      prev = k;
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.weight_valid = 1'b0;
        drive_result(prev);
        prev = -1;
        @(negedge clk);
      end
    end
    bus.weight_valid = 1'b0;
    if (prev >= 0) begin
      drive_result(prev);
      @(negedge clk);
    end
    idle_bus();
  endtask

  task automatic finish_and_check(input string tag);
    int c = 0;
    while (!mapping_done && c < 4 * N) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, mapping_done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fail"}, mapping_fail, exp_fail);
    check({tag, "_perr"}, protocol_err, exp_perr);
    check({tag, "_used"}, row_used, exp_used);
    for (int i = 0; i < N; i++) begin
      bus.map_rd_addr = AW'(i);
      #1;
      check($sformatf("%s_map%0d", tag, i), bus.map_rd_phys, exp_map[i]);
    end
  endtask

  task automatic gen_random(input logic [N-1:0] m);
    int  perm[N];
    bit  claimed[N];
    int  cand[$];
    clear_ops();
    for (int i = 0; i < N; i++) begin perm[i] = i; claimed[i] = 0; end
    for (int i = N - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int k = 0; k < N; k++) begin
      cand.delete();
      for (int q = 0; q < N; q++) if (m[q] && !claimed[q]) cand.push_back(q);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        int p = cand[$urandom_range(0, cand.size() - 1)];
        claimed[p] = 1;
        push_op(perm[k], 1, p);
      end else begin
        push_op(perm[k], 0, 0);
      end
    end
    if ($urandom_range(0, 3) == 0) begin
      int j = $urandom_range(0, N - 2);
      op_row.insert(j + 1, op_row[j]);
      op_ok.insert(j + 1, 0);
      op_phys.insert(j + 1, 0);
    end
  endtask

  initial begin
    idle_bus();
    bus.map_rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", mapping_done, 0);
    check("rst_fail", mapping_fail, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_used", row_used, 0);
    for (int i = 0; i < N; i++) begin
      bus.map_rd_addr = AW'(i);
      #1;
      check($sformatf("rst_map%0d", i), bus.map_rd_phys, i);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Clean array, every row deferred: identity map.
    all_failed();
    start_and_drive(8'h00, 0);
    finish_and_check("ident");

    // Result while DONE is a protocol error.
    @(negedge clk);
    bus.match_failed = 1'b1;
    @(negedge clk);
    bus.match_failed = 1'b0;
    check("perr_outside_collect", protocol_err, 1);
    check("done_held", mapping_done, 1);

    // Two matched faulty rows, the rest fill the clean rows in order.
    clear_ops();
    for (int i = 0; i < N; i++) push_op(i, (i == 3 || i == 6) ? 1 : 0, (i == 3) ? 0 : 2);
    start_and_drive(8'h05, 1);
    finish_and_check("mask05");
    bus.map_rd_addr = AW'(3); #1; check("m05_row3", bus.map_rd_phys, 0);
    bus.map_rd_addr = AW'(6); #1; check("m05_row6", bus.map_rd_phys, 2);

    // Clean rows exhausted: rows 6,7 land on faulty rows 0,7.
    all_failed();
    start_and_drive(8'h81, 0);
    finish_and_check("mask81");
    check("m81_fail", mapping_fail, 1);
    check("m81_used", row_used, 8'hFF);

    // Back-to-back, then a duplicate row 2.
    all_failed();
    start_and_drive(8'h10, 0);
    finish_and_check("b2b");
    clear_ops();
    push_op(0, 0, 0); push_op(1, 0, 0); push_op(2, 0, 0); push_op(2, 0, 0);
    for (int i = 3; i < N; i++) push_op(i, 0, 0);
    start_and_drive(8'h00, 0);
    finish_and_check("dup");
    check("dup_perr", protocol_err, 1);

    // Reset during ALLOC after three allocations.
    all_failed();
    start_and_drive(8'h00, 0);
    for (int c = 0; c < 20 && $countones(row_used) < 3; c++) @(negedge clk);
    check("alloc3_used", $countones(row_used), 3);
    check("alloc3_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", mapping_done, 0);
    check("mid_rst_fail", mapping_fail, 0);
    check("mid_rst_perr", protocol_err, 0);
    check("mid_rst_used", row_used, 0);
    for (int i = 0; i < N; i++) begin
      bus.map_rd_addr = AW'(i);
      #1;
      check($sformatf("mid_rst_map%0d", i), bus.map_rd_phys, i);
    end
    @(negedge clk);
    rst_n = 1'b1;
    all_failed();
    start_and_drive(8'h24, 1);
    finish_and_check("post_rst");

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      logic [N-1:0] m = N'($urandom);
      gen_random(m);
      start_and_drive(m, 1);
      finish_and_check($sformatf("rnd%0d", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mapping_table.md
MAPPING_TABLE -- requirements
Module: mapping_table

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, meaning array rows/columns (N).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(SYSTOLIC_SIZE), meaning row index width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a mapping session.
REQ-007 SHALL have port faulty_rows_mask  input  N  bit i = physical row i has a fault; sampled on start.
REQ-008 SHALL have port weight_valid  input  1  one logical weight row presented to faulty PE storage this cycle.
REQ-009 SHALL have port current_row_addr  input  ADDR_WIDTH  logical weight row index accompanying weight_valid.
REQ-010 SHALL have port match_success  input  1  storage result: previous-cycle row matched a faulty row.
REQ-011 SHALL have port match_failed  input  1  storage result: previous-cycle row unmatched; needs step-4 allocation.
REQ-012 SHALL have port faulty_row_addr  input  ADDR_WIDTH  physical faulty row assigned on match_success.
REQ-013 SHALL have port map_rd_addr  input  ADDR_WIDTH  logical row to look up.
REQ-014 SHALL have port map_rd_phys  output  ADDR_WIDTH  physical row mapped to map_rd_addr, combinational.
REQ-015 SHALL have port row_used  output  N  bit i = physical row i already allocated.
REQ-016 SHALL have port busy  output  1  high in COLLECT or ALLOC.
REQ-017 SHALL have port mapping_done  output  1  high in DONE/FAIL until next start.
REQ-018 SHALL have port mapping_fail  output  1  high in FAIL: a logical row landed on an unmatched faulty row.
REQ-019 SHALL have port protocol_err  output  1  sticky: duplicate logical row or result outside COLLECT.

Function
REQ-020 SHALL implement states IDLE, COLLECT, ALLOC, DONE, FAIL; DONE and FAIL accept start like IDLE.
REQ-021 On start outside COLLECT/ALLOC: latch mask, clear row_used, defer list, seen bits, result counter, protocol_err; map[i]=i; go COLLECT. start while busy is ignored.
REQ-022 In COLLECT, weight_valid shall capture current_row_addr into a one-deep pipeline register; the result arrives the following cycle; back-to-back weight_valid supported.
REQ-023 On match_success: map[pending]=faulty_row_addr, row_used[faulty_row_addr]=1, seen[pending]=1, counter+1.
REQ-024 On match_failed: defer[pending]=1, seen[pending]=1, counter+1.
REQ-025 Result for a pending row already seen shall set protocol_err and be otherwise ignored (no counter change).
REQ-026 Result arriving in IDLE/ALLOC/DONE/FAIL, or both success and failed high, shall set protocol_err and be ignored.
REQ-027 When counter reaches N (counter width $clog2(N+1)), next state shall be ALLOC.
REQ-028 ALLOC shall serve one deferred logical row per cycle, lowest index first: physical = lowest-index row with row_used=0 and mask=0; if none, lowest-index row with row_used=0.
REQ-029 Each allocation shall write map, set row_used, clear defer bit; allocating a masked row sets a sticky fail flag.
REQ-030 When no defer bits remain (including zero on entry), ALLOC shall go to FAIL if fail flag set, else DONE.
REQ-031 Invariant: after ALLOC, row_used is all ones and map is a permutation of 0..N-1.
REQ-032 map_rd_phys shall reflect the current map array at any state.

Reset
REQ-033 Reset shall force state IDLE, map[i]=i, row_used=0, defer=0, seen=0, counter=0, pipeline register 0, busy=0, mapping_done=0, mapping_fail=0, protocol_err=0.
REQ-034 Reset asserted mid-COLLECT or mid-ALLOC shall abort immediately with the values of REQ-033; no partial map is retained.

Verification
REQ-035 N=8, mask=0x00, eight weight_valid rows 0..7 all answered match_failed -> ALLOC 8 cycles, map identity, mapping_done=1, mapping_fail=0.
REQ-036 mask=0x05, row 3 -> success phys 0, row 6 -> success phys 2, rest failed -> map[3]=0, map[6]=2, rows 0,1,2,4,5,7 -> 1,3,4,5,6,7; done, fail=0.
REQ-037 mask=0x81, all eight rows failed -> rows 0..5 get phys 1..6, rows 6,7 get phys 0,7; mapping_fail=1, row_used=0xFF.
REQ-038 Back-to-back weight_valid rows 0..7 with results each following cycle -> counter reaches 8 with no protocol_err; row 2 presented twice -> protocol_err=1.
REQ-039 Reset pulsed during ALLOC after 3 allocations -> all outputs at REQ-033 values; new start completes normally.
